// File: rtl/mmio_fifo_ctrl.sv
// rtl/mmio_fifo_ctrl.sv - MMIO-mapped 64-bit queue with status/control registers and registered read responses
module mmio_fifo_ctrl #(
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DATA_ADDR   = 16'h0020,
    parameter logic [15:0] STATUS_ADDR = 16'h0022,
    parameter logic [15:0] CTRL_ADDR   = 16'h0024,
    localparam int         CW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [15:0]   wr_addr,
    input  logic [63:0]   wr_data,
    input  logic          rd_valid,
    input  logic [15:0]   rd_addr,
    input  logic [8:0]    rd_tid,
    output logic          rsp_valid,
    output logic [8:0]    rsp_tid,
    output logic [63:0]   rsp_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          overflow;
    logic          underflow;

    logic          push_req;
    logic          pop_req;
    logic          do_push;
    logic          do_pop;
    logic          flush;
    logic          clr_flags;
    logic          ovf_set;
    logic          udf_set;
    logic [CW-1:0] count_next;
    logic [63:0]   status_word;
    logic [63:0]   rd_word;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign push_req  = wr_valid && (wr_addr == DATA_ADDR);
    assign pop_req   = rd_valid && (rd_addr == DATA_ADDR);
    assign flush     = wr_valid && (wr_addr == CTRL_ADDR) && wr_data[0];
    assign clr_flags = wr_valid && (wr_addr == CTRL_ADDR) && wr_data[1];

    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign do_pop  = pop_req && !empty;
    assign do_push = push_req && (!full || do_pop);
    assign ovf_set = push_req && full && !do_pop;
    assign udf_set = pop_req && empty;

    assign status_word = {32'h0, overflow, underflow, full, empty, 12'h0, 16'(count)};

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        rd_word = 64'h0;
        if (rd_addr == DATA_ADDR) begin
            rd_word = empty ? 64'h0 : mem[head];
        end else if (rd_addr == STATUS_ADDR) begin
            rd_word = status_word;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rsp_valid <= rd_valid;
            if (rd_valid) begin
                rsp_tid  <= rd_tid;
                rsp_data <= rd_word;
            end
            // Flush overrides pointer/count updates; the pop response above still sees the old head.
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_push) tail <= tail + 1'b1;
                if (do_pop)  head <= head + 1'b1;
                count <= count_next;
            end
            overflow  <= ovf_set | (overflow & ~clr_flags);
            underflow <= udf_set | (underflow & ~clr_flags);
        end
    end
endmodule

// File: doc/mmio_fifo_ctrl.md
# mmio_fifo_ctrl

MMIO-facing controller that owns a 64-bit data queue behind the AFU's user register space. Host MMIO writes to the data address push entries, and MMIO reads from it pop entries. Status and control addresses expose occupancy and sticky error flags, and allow flush and flag clear. It sits between the AFU's decoded CCI-P MMIO request fields and the Tx c2 read-response registers, and replaces ad-hoc push/read wiring with a sequenced push/pop/response path.

## Interface

Parameters:
- DEPTH, 8 — queue entries; power of two, at least 2.
- DATA_ADDR, 16'h0020 — write pushes, read pops.
- STATUS_ADDR, 16'h0022 — read-only status word.
- CTRL_ADDR, 16'h0024 — write-only control word.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- wr_valid  in  1  MMIO write strobe, one cycle per request.
- wr_addr  in  16  MMIO write address (DWORD units).
- wr_data  in  64  MMIO write data.
- rd_valid  in  1  MMIO read strobe, one cycle per request.
- rd_addr  in  16  MMIO read address.
- rd_tid  in  9  MMIO read transaction ID.
- rsp_valid  out  1  read response strobe (drives tx.c2.mmioRdValid).
- rsp_tid  out  9  echoed TID.
- rsp_data  out  64  response data.
- count  out  CW  occupancy, where CW = $clog2(DEPTH+1).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation

- Storage: DEPTH x 64 register array, head pointer, tail pointer, and count. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The array is not reset.
- Push: wr_valid with wr_addr == DATA_ADDR.
  - Not full: write mem[tail], increment tail and count.
  - Full, no simultaneous pop: data is dropped and the overflow flag is set.
  - Full, simultaneous pop: the push is accepted and count is unchanged.
- Pop: rd_valid with rd_addr == DATA_ADDR.
  - Not empty: respond with mem[head], increment head, decrement count.
  - Empty: respond with 64'h0 and set the underflow flag. A simultaneous push is still accepted; there is no bypass, so the pushed data is not returned by this read.
- Status read: rd_addr == STATUS_ADDR. Response is:
  - [63:32] = 0
  - [31] = overflow
  - [30] = underflow
  - [29] = full
  - [28] = empty
  - [27:16] = 0
  - [15:0] = count, zero-extended
- Control write: wr_addr == CTRL_ADDR.
  - bit0 = flush: head, tail and count go to 0.
  - bit1 = clear overflow and underflow.
  - Both bits may be set in the same write. If a flush coincides with a pop, the pop response still returns the pre-flush head entry and the flush wins for pointer and count state.
- Any other read address: response with 64'h0, no state change. Writes to other addresses, and reads of CTRL_ADDR (which return 0), are ignored.
- rd_valid and wr_valid may both be asserted in the same cycle. Both requests are processed.
- Sticky flags: set by an event and held until a clear or reset. A set event in the same cycle as a clear wins, so the flag remains 1.

## Timing

- Reset values: rsp_valid=0, rsp_tid=0, rsp_data=0, count=0, empty=1, full=0, overflow=0, underflow=0, pointers=0.
- Read latency: rsp_valid, rsp_tid and rsp_data are registered and assert exactly one cycle after the rd_valid cycle. rsp_valid is a single-cycle pulse.
- rsp_data and rsp_tid hold their value when rsp_valid=0.
- Back-to-back reads on consecutive cycles each produce a response on consecutive cycles. No stall or backpressure exists.
- Status reads sample state before that cycle's push, pop or control update.
- count, full and empty are registered and reflect updates on the clock edge following the request.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to reset values. A response pending for the next edge is discarded.

## Test plan

- Reset, then read STATUS_ADDR (tid 9'h05) -> 1 cycle later rsp_valid=1, rsp_tid=9'h05, rsp_data=64'h0000_0000_1000_0000.
- Push 64'hA1, 64'hB2, 64'hC3, then 3 DATA_ADDR reads -> responses A1, B2, C3 in order, each 1 cycle after its read. Final state: count=0, empty=1.
- Push 9 entries (DEPTH=8) -> the 9th is dropped, count=8, full=1, status bit31=1. Then 8 pops return entries 1-8.
- Pop while empty -> rsp_data=0, status bit30=1. Write CTRL=2'b10 -> bits 31:30 read 0.
- Full FIFO with simultaneous push(64'hDD) and pop -> pop returns the oldest entry, count stays 8, no overflow. After 7 further pops, the next pop returns DD (pointer wrap checked).
- Push 3 entries, write CTRL=1 (flush) -> count=0, empty=1. Assert rst in the cycle after a pop request -> no rsp_valid, all outputs at reset values.
